// File: rtl/mash_if.sv
// Control/data bundle between a fractional-word source and the MASH modulator.
interface mash_if #(
  parameter int BITS  = 8,
  parameter int ORDER = 3
) ();
  logic                    en;
  logic                    f_load;
  logic [BITS-1:0]         f;
  logic signed [ORDER:0]   dn;
  logic                    dn_valid;

  modport master (output en, f_load, f, input dn, dn_valid);
  modport slave  (input en, f_load, f, output dn, dn_valid);
endinterface

// File: rtl/mash_nth_order.sv
// MASH 1-1-..-1 sigma-delta modulator of selectable order for the fractional-N divider.
// dn is the signed per-cycle divider offset; its long-run mean is f/2^BITS.
module mash_nth_order #(
  parameter int BITS  = 8,
  parameter int ORDER = 3
) (
  input logic   clk,
  input logic   rst,
  mash_if.slave bus
);
  localparam int OW = ORDER + 1;

  function automatic logic signed [OW-1:0] carry_ext(input logic cb);
    return $signed({{ORDER{1'b0}}, cb});
  endfunction

  logic [BITS-1:0]       f_q;
  logic [BITS-1:0]       acc   [ORDER];
  logic [BITS-1:0]       in_w  [ORDER];
  logic [BITS:0]         sum   [ORDER];
  logic [ORDER-1:0]      c;
  logic                  c_al  [ORDER];
  logic signed [OW-1:0]  y     [ORDER];
  logic signed [OW-1:0]  y_dly [ORDER];
  logic [ORDER:0]        vld_sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_q <= '0;
    end else if (bus.en && bus.f_load) begin
      f_q <= bus.f;
    end
  end

  // Accumulator cascade: each stage integrates the previous stage's registered residue
  always_comb begin
    in_w[0] = f_q;
    for (int k = 1; k < ORDER; k++) begin
      in_w[k] = acc[k-1];
    end
    for (int k = 0; k < ORDER; k++) begin
      sum[k] = {1'b0, acc[k]} + {1'b0, in_w[k]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < ORDER; k++) begin
        acc[k] <= '0;
      end
      c <= '0;
    end else if (bus.en) begin
      for (int k = 0; k < ORDER; k++) begin
        acc[k] <= sum[k][BITS-1:0];
        c[k]   <= sum[k][BITS];
      end
    end
  end

  // Carry alignment: stage k lags stage 0 by k cycles, so c_k waits ORDER-1-k cycles
  for (genvar k = 0; k < ORDER; k++) begin : g_align
    localparam int D = ORDER - 1 - k;
    if (D == 0) begin : g_direct
      assign c_al[k] = c[k];
    end else begin : g_delay
      logic [D-1:0] c_dly_p1;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          c_dly_p1 <= '0;
        end else if (bus.en) begin
          c_dly_p1 <= (c_dly_p1 << 1) | D'(c[k]);
        end
      end
      assign c_al[k] = c_dly_p1[D-1];
    end
  end

  // Recombination, innermost level first: y_k = c_k + (1 - z^-1) y_{k+1}
  always_comb begin
    y[ORDER-1] = carry_ext(c_al[ORDER-1]);
    for (int k = ORDER - 2; k >= 0; k--) begin
      y[k] = carry_ext(c_al[k]) + y[k+1] - y_dly[k+1];
    end
  end

  // Per-level registers; level 0 is the registered dn output itself
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < ORDER; k++) begin
        y_dly[k] <= '0;
      end
      vld_sr <= '0;
    end else if (bus.en) begin
      for (int k = 0; k < ORDER; k++) begin
        y_dly[k] <= y[k];
      end
      vld_sr <= {vld_sr[ORDER-1:0], 1'b1};
    end
  end

  assign bus.dn       = y_dly[0];
  assign bus.dn_valid = vld_sr[ORDER];
endmodule

// File: doc/mash_nth_order.md
Name: mash_nth_order

Overview:
Parametrised MASH 1-1-…-1 sigma-delta modulator for the fractional-N PLL divider path. It generalises the fixed third-order MASH to a selectable order of 1 to 4 and a configurable accumulator width. It adds asynchronous reset, a clock-enable and a loaded fractional word. It emits a signed per-cycle divider offset dn whose long-term mean equals f/2^BITS.

Parameters:
BITS, 8, accumulator and fractional-word width (4..24)
ORDER, 3, modulator order, number of cascaded accumulator stages (1..4)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-high reset
en  input  1  clock enable; low freezes all state and outputs
f  input  BITS  unsigned fractional word
f_load  input  1  capture f into f_q on this enabled edge
dn  output  ORDER+1  signed two's-complement divider offset
dn_valid  output  1  high once pipeline is primed after reset

Behaviour:
- Reset (async, any time, including mid-operation): f_q, all accumulators acc_k, all carry/delay/pipeline registers, dn and dn_valid go to 0 immediately. Operation resumes on the first enabled edge after rst deasserts.
- en=0: no register changes, including f_q (f_load ignored). dn and dn_valid hold.
- f_load=1 with en=1: f_q <= f. The new value enters stage 0 on the following enabled edge.
- Stage k (k=0..ORDER-1), on each enabled edge:
  - {c_k, acc_k} <= acc_k + in_k, computed at BITS+1 bits, with modulo-2^BITS wrap.
  - in_0 = f_q; in_k = acc_{k-1} (registered, pre-update value).
  - c_k is a registered carry (0/1).
- Recombination, registered per level, innermost first:
  - y_{ORDER-1} = c_{ORDER-1}.
  - y_k = c_k(aligned) + y_{k+1} − y_{k+1} delayed one enabled cycle.
  - All arithmetic sign-extended to ORDER+1 bits; no saturation is needed.
  - c_k is delayed so that every term in a sum derives from the same input sample, i.e. dn = Σ_k (1−z⁻¹)^k c_k with stage-matched alignment.
- dn = y_0, registered.
- Latency: a change of f_q affects dn exactly ORDER+1 enabled cycles after the edge that loads it into stage 0. Reproduce the bit-exact latency from the golden model (Python model in the same testbench directory).
- Output range, guaranteed:
  - ORDER=1: {0,1}
  - ORDER=2: −1..2
  - ORDER=3: −3..4
  - ORDER=4: −7..8
- dn_valid rises after ORDER+1 enabled cycles following reset and stays high until the next reset. dn is 0 before dn_valid.
- f_q=0: all carries stay 0, so dn=0 forever.
- Long-run sum: starting from reset state, Σdn over N enabled cycles = ⌊N·f/2^BITS⌋ + e with |e| ≤ 2^(ORDER−1). For N a multiple of 2^BITS and ORDER=1, e=0.
- Simultaneous f_load and wrap events: no special case; the carry uses the pre-load f_q.

Test Plan:
- BITS=8, ORDER=3, f=0, f_load pulse, 1000 cycles -> dn=0 every cycle; dn_valid high from cycle 4 after reset.
- ORDER=1, f=128, 512 cycles -> dn alternates 0,1 after latency; sum over 256 cycles = 128.
- ORDER=3, f=77, 25600 cycles -> every dn in −3..4; |Σdn − 7700| ≤ 4; sequence bit-exact against golden model.
- ORDER=4, f=255, compare to model -> dn in −7..8, bit-exact; change f to 1 mid-run -> new trend visible exactly ORDER+1 cycles after the load edge.
- en toggled low for 20 random stretches -> dn frozen during each stretch; after re-enable the sequence is identical to the en-always-high run with gaps removed.
- rst asserted asynchronously mid-cycle during nonzero dn -> dn, dn_valid, f_q = 0 immediately; after release with f reloaded, output matches a fresh run.
